// File: rtl/pixel_sink_pkg.sv
// Shared types and helpers for the pixel stream sink: FSM states, coordinate type
// and framebuffer sizing.
package pixel_sink_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic signed [31:0] coord_t;

  function automatic int fb_depth(input int width, input int height);
    return width * height;
  endfunction

endpackage

// File: rtl/pixel_stream_sink_fb_addr_calc.sv
// Combinational clip check and linear address (y*WIDTH + x) for one coordinate beat.
module fb_addr_calc
  import pixel_sink_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 12,
  parameter int ADDR_W = 8
) (
  input  logic signed [31:0] i_x,
  input  logic signed [31:0] i_y,
  output logic               o_in_bounds,
  output logic [ADDR_W-1:0]  o_addr
);

  localparam coord_t X_LIM = coord_t'(WIDTH);
  localparam coord_t Y_LIM = coord_t'(HEIGHT);
  localparam coord_t ZERO  = coord_t'(0);

  // Full signed compares so huge or negative coordinates never alias into range.
  assign o_in_bounds = (i_x >= ZERO) && (i_x < X_LIM) && (i_y >= ZERO) && (i_y < Y_LIM);
  assign o_addr      = ADDR_W'(i_y * X_LIM + i_x);

endmodule

// File: rtl/pixel_stream_sink.sv
// Consumes generator (x, y) beats, clips them to the framebuffer and writes the draw
// colour through a one-entry stage; optionally clears the framebuffer first.
module pixel_stream_sink
  import pixel_sink_pkg::*;
#(
  parameter int                 WIDTH    = 16,
  parameter int                 HEIGHT   = 12,
  parameter int                 COLOR_W  = 8,
  parameter int                 ADDR_W   = $clog2(fb_depth(WIDTH, HEIGHT)),
  parameter int                 CLEAR_EN = 1,
  parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [COLOR_W-1:0]  i_draw_color,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic signed [31:0]  i_in_x,
  input  logic signed [31:0]  i_in_y,
  input  logic                i_in_last,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [COLOR_W-1:0]  o_mem_wdata,
  input  logic                i_mem_ready,
  output logic [31:0]         o_pixels_written,
  output logic [31:0]         o_pixels_clipped,
  output logic                o_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(fb_depth(WIDTH, HEIGHT) - 1);

  state_t             r_state;
  state_t             w_stateNext;
  logic [ADDR_W-1:0]  r_clearAddr;
  logic [ADDR_W-1:0]  r_sAddr;
  logic               r_sValid;
  logic               r_lastSeen;
  logic [COLOR_W-1:0] r_color;
  logic [31:0]        r_written;
  logic [31:0]        r_clipped;
  logic               w_inBounds;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_fire;
  logic               w_wrDone;

  fb_addr_calc #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .ADDR_W(ADDR_W)
  ) u_addr_calc (
    .i_x        (i_in_x),
    .i_y        (i_in_y),
    .o_in_bounds(w_inBounds),
    .o_addr     (w_addr)
  );

  assign w_fire   = i_in_valid && o_in_ready;
  assign w_wrDone = o_mem_we && i_mem_ready;

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    if (i_start) begin
      w_stateNext = (CLEAR_EN != 0) ? CLEAR : DRAW;
    end else begin
      case (r_state)
        CLEAR:   if (i_mem_ready && (r_clearAddr == LAST_ADDR)) w_stateNext = DRAW;
        DRAW:    if (r_lastSeen && !r_sValid && !w_fire) w_stateNext = DONE;
        default: w_stateNext = r_state;
      endcase
    end
  end

  always_comb begin
    o_in_ready  = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_done      = 1'b0;
    case (r_state)
      CLEAR: begin
        o_mem_we    = 1'b1;
        o_mem_addr  = r_clearAddr;
        o_mem_wdata = BG_COLOR;
      end
      DRAW: begin
        // A new beat may load in the same cycle the staged write is accepted.
        o_in_ready  = !r_sValid || i_mem_ready;
        o_mem_we    = r_sValid;
        o_mem_addr  = r_sAddr;
        o_mem_wdata = r_color;
      end
      DONE:    o_done = 1'b1;
      default: o_done = 1'b0;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_clearAddr <= '0;
      r_sAddr     <= '0;
      r_sValid    <= 1'b0;
      r_lastSeen  <= 1'b0;
      r_color     <= '0;
      r_written   <= '0;
      r_clipped   <= '0;
    end else if (i_start) begin
      r_clearAddr <= '0;
      r_sValid    <= 1'b0;
      r_lastSeen  <= 1'b0;
      r_color     <= i_draw_color;
      r_written   <= '0;
      r_clipped   <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          if (i_in_last) r_lastSeen <= 1'b1;
          if (i_mem_ready) r_clearAddr <= (r_clearAddr == LAST_ADDR) ? '0 : r_clearAddr + 1'b1;
        end
        DRAW: begin
          if (i_in_last) r_lastSeen <= 1'b1;
          if (w_fire && w_inBounds) begin
            r_sValid <= 1'b1;
            r_sAddr  <= w_addr;
          end else if (w_wrDone) begin
            r_sValid <= 1'b0;
          end
          if (w_fire && !w_inBounds) r_clipped <= r_clipped + 32'd1;
          if (w_wrDone) r_written <= r_written + 32'd1;
        end
        default: r_lastSeen <= r_lastSeen;
      endcase
    end
  end

  assign o_pixels_written = r_written;
  assign o_pixels_clipped = r_clipped;

endmodule

// File: tb/tb_pixel_stream_sink.sv
// Self-checking bench for pixel_stream_sink: directed vector table, stall/done sequences,
// circle and random frames scored against a coordinate-level reference model.
module tb_pixel_stream_sink;

  localparam int FB_W  = 16;
  localparam int FB_H  = 12;
  localparam int DEPTH = FB_W * FB_H;

  typedef struct {
    logic signed [31:0] x;
    logic signed [31:0] y;
  } beat_t;

  typedef struct {
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic               expWe;
    logic [7:0]         expAddr;
  } vec_t;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic [7:0]         drawColor;
  logic               inValid;
  logic               inReady;
  logic signed [31:0] inX;
  logic signed [31:0] inY;
  logic               inLast;
  logic               memWe;
  logic [7:0]         memAddr;
  logic [7:0]         memWdata;
  logic               memReady;
  logic [31:0]        pixWritten;
  logic [31:0]        pixClipped;
  logic               frameDone;

  int    checks = 0;
  int    passed = 0;
  int    clr;
  beat_t frameBeats[$];
  vec_t  vecs[8];

  always #5 clock = ~clock;

  pixel_stream_sink dut (
    .i_clock         (clock),
    .i_reset         (reset),
    .i_start         (start),
    .i_draw_color    (drawColor),
    .i_in_valid      (inValid),
    .o_in_ready      (inReady),
    .i_in_x          (inX),
    .i_in_y          (inY),
    .i_in_last       (inLast),
    .o_mem_we        (memWe),
    .o_mem_addr      (memAddr),
    .o_mem_wdata     (memWdata),
    .i_mem_ready     (memReady),
    .o_pixels_written(pixWritten),
    .o_pixels_clipped(pixClipped),
    .o_done          (frameDone)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic valid, input logic signed [31:0] x, input logic signed [31:0] y,
                               input logic last, input logic mready);
    inValid  = valid;
    inX      = x;
    inY      = y;
    inLast   = last;
    memReady = mready;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  function automatic bit refInBounds(input logic signed [31:0] x, input logic signed [31:0] y);
    longint lx = longint'(x);
    longint ly = longint'(y);
    return (lx >= 0) && (lx < FB_W) && (ly >= 0) && (ly < FB_H);
  endfunction

  function automatic int refAddr(input logic signed [31:0] x, input logic signed [31:0] y);
    return int'(longint'(y) * FB_W + longint'(x));
  endfunction

  task automatic pushBeat(input int x, input int y);
    beat_t b;
    b.x = x;
    b.y = y;
    frameBeats.push_back(b);
  endtask

  // Midpoint circle, all eight octants emitted per step (seam duplicates kept).
  task automatic buildCircle(input int cx, input int cy, input int r);
    int x = 0;
    int y = r;
    int d = 1 - r;
    frameBeats.delete();
    while (x <= y) begin
      pushBeat(cx + x, cy + y); pushBeat(cx - x, cy + y);
      pushBeat(cx + x, cy - y); pushBeat(cx - x, cy - y);
      pushBeat(cx + y, cy + x); pushBeat(cx - y, cy + x);
      pushBeat(cx + y, cy - x); pushBeat(cx - y, cy - x);
      x++;
      if (d < 0) d += 2 * x + 1;
      else begin
        y--;
        d += 2 * (x - y) + 1;
      end
    end
  endtask

  task automatic buildRandom(input int n);
    frameBeats.delete();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) pushBeat(int'($urandom), int'($urandom));
      else pushBeat(int'($urandom_range(0, 23)) - 4, int'($urandom_range(0, 19)) - 4);
    end
  endtask

  task automatic startFrame(input logic [7:0] color);
    int waitCyc = 0;
    nextCycle();
    start     = 1'b1;
    drawColor = color;
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    nextCycle();
    start = 1'b0;
    #1;
    while (!inReady && waitCyc < 400) begin
      nextCycle();
      waitCyc++;
    end
    checkOutput("start_reaches_draw", 32'(inReady), 1);
  endtask

  // Drives frameBeats with random valid gaps and memory stalls, scoring every write.
  task automatic runFrame(input string tag, input logic [7:0] color);
    int expAddr[$];
    int expClip  = 0;
    int expWrite;
    int sent     = 0;
    int lastWr   = -1;
    int doneCyc  = -1;
    int a;
    bit hold     = 1'b0;
    bit v        = 1'b0;
    bit mr;
    foreach (frameBeats[i]) begin
      if (refInBounds(frameBeats[i].x, frameBeats[i].y)) expAddr.push_back(refAddr(frameBeats[i].x, frameBeats[i].y));
      else expClip++;
    end
    expWrite = expAddr.size();
    for (int c = 0; c < 3000 && doneCyc < 0; c++) begin
      nextCycle();
      mr = ($urandom_range(0, 3) != 0);
      if (!hold) v = (sent < frameBeats.size()) && ($urandom_range(0, 3) != 0);
      if (sent < frameBeats.size()) applyStimulus(v, frameBeats[sent].x, frameBeats[sent].y, 1'b0, mr);
      else applyStimulus(1'b0, 0, 0, 1'b1, mr);
      if (frameDone) doneCyc = c;
      if (memWe && memReady) begin
        if (expAddr.size() == 0) begin
          checks++;
          $display("[TB] FAIL %s_extra_write: actual addr=%0d required no write", tag, memAddr);
        end else begin
          a = expAddr.pop_front();
          checkOutput({tag, "_addr"}, 32'(memAddr), 32'(a));
          checkOutput({tag, "_wdata"}, 32'(memWdata), 32'(color));
        end
        lastWr = c;
      end
      if (inValid && inReady) begin
        sent++;
        hold = 1'b0;
      end else begin
        hold = inValid;
      end
    end
    checkOutput({tag, "_done_seen"}, 32'(doneCyc >= 0), 1);
    if (doneCyc >= 0) checkOutput({tag, "_done_latency"}, 32'(doneCyc - lastWr), 2);
    checkOutput({tag, "_written"}, pixWritten, 32'(expWrite));
    checkOutput({tag, "_clipped"}, pixClipped, 32'(expClip));
    checkOutput({tag, "_beat_total"}, pixWritten + pixClipped, 32'(frameBeats.size()));
    checkOutput({tag, "_pending_left"}, 32'(expAddr.size()), 0);
  endtask

  initial begin
    vecs[0] = '{32'sd3,  32'sd2,  1'b1, 8'd35};
    vecs[1] = '{32'sd15, 32'sd11, 1'b1, 8'd191};
    vecs[2] = '{32'sd0,  32'sd0,  1'b1, 8'd0};
    vecs[3] = '{-32'sd1, 32'sd0,  1'b0, 8'd0};
    vecs[4] = '{32'sd16, 32'sd0,  1'b0, 8'd0};
    vecs[5] = '{32'sd0,  32'sd12, 1'b0, 8'd0};
    vecs[6] = '{32'sd0,  32'sh80000000, 1'b0, 8'd0};
    vecs[7] = '{32'sd7,  32'sd5,  1'b1, 8'd87};

    // Reset held with start asserted: reset must win.
    reset     = 1'b1;
    start     = 1'b1;
    drawColor = 8'd0;
    inValid   = 1'b0;
    inX       = 0;
    inY       = 0;
    inLast    = 1'b0;
    memReady  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    start = 1'b0;
    repeat (5) nextCycle();
    checkOutput("idle_ready", 32'(inReady), 0);
    checkOutput("idle_we", 32'(memWe), 0);
    checkOutput("idle_addr", 32'(memAddr), 0);
    checkOutput("idle_wdata", 32'(memWdata), 0);
    checkOutput("idle_written", pixWritten, 0);
    checkOutput("idle_clipped", pixClipped, 0);
    checkOutput("idle_done", 32'(frameDone), 0);

    // Clear pass: 192 background writes, then DRAW on cycle 193.
    nextCycle();
    start     = 1'b1;
    drawColor = 8'd5;
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    nextCycle();
    start = 1'b0;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("clear_beat", 32'({memWe, inReady, memWdata, memAddr}), 32'({1'b1, 1'b0, 8'h00, 8'(i)}));
      nextCycle();
    end
    checkOutput("draw_ready", 32'(inReady), 1);
    checkOutput("draw_we_idle", 32'(memWe), 0);
    checkOutput("clear_not_counted", pixWritten, 0);

    // Vector table: beat k accepted, its write (or absence) visible at k+1.
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) applyStimulus(1'b1, vecs[k].x, vecs[k].y, 1'b0, 1'b1);
      else applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
      checkOutput("tbl_ready", 32'(inReady), 1);
      if (k > 0) begin
        checkOutput("tbl_we", 32'(memWe), 32'(vecs[k-1].expWe));
        if (vecs[k-1].expWe) begin
          checkOutput("tbl_addr", 32'(memAddr), 32'(vecs[k-1].expAddr));
          checkOutput("tbl_wdata", 32'(memWdata), 5);
        end
      end
      nextCycle();
    end
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    checkOutput("tbl_written", pixWritten, 4);
    checkOutput("tbl_clipped", pixClipped, 4);

    // Backpressure: (1,1) staged while memory stalls, (2,1) held until it drains.
    nextCycle();
    applyStimulus(1'b1, 1, 1, 1'b0, 1'b1);
    checkOutput("stall_first_ready", 32'(inReady), 1);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2, 1, 1'b0, 1'b0);
      checkOutput("stall_addr", 32'(memAddr), 17);
      checkOutput("stall_we", 32'(memWe), 1);
      checkOutput("stall_ready", 32'(inReady), 0);
      nextCycle();
    end
    applyStimulus(1'b1, 2, 1, 1'b0, 1'b1);
    checkOutput("release_ready", 32'(inReady), 1);
    checkOutput("release_addr", 32'(memAddr), 17);
    nextCycle();
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    checkOutput("second_we", 32'(memWe), 1);
    checkOutput("second_addr", 32'(memAddr), 18);

    // in_last pulse with the stage empty: DONE two samples later.
    nextCycle();
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);
    checkOutput("drained_we", 32'(memWe), 0);
    checkOutput("drained_written", pixWritten, 6);
    checkOutput("pre_done", 32'(frameDone), 0);
    nextCycle();
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    checkOutput("last_seen_done", 32'(frameDone), 0);
    nextCycle();
    checkOutput("done_set", 32'(frameDone), 1);
    checkOutput("done_ready", 32'(inReady), 0);
    checkOutput("done_we", 32'(memWe), 0);
    nextCycle();
    checkOutput("done_held", 32'(frameDone), 1);
    checkOutput("done_written", pixWritten, 6);
    checkOutput("done_clipped", pixClipped, 4);

    // Circle frame, centre (8,6), radius 3.
    buildCircle(8, 6, 3);
    startFrame(8'h09);
    runFrame("circle", 8'h09);

    // Random frame including far out-of-range coordinates.
    buildRandom(60);
    drawColor = 8'($urandom);
    startFrame(drawColor);
    runFrame("rand", drawColor);

    // Restart mid-DRAW with a write still pending.
    startFrame(8'h3C);
    applyStimulus(1'b1, 2, 3, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 4, 4, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    checkOutput("pending_addr", 32'(memAddr), 68);
    checkOutput("pending_written", pixWritten, 1);
    nextCycle();
    start = 1'b1;
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    nextCycle();
    start = 1'b0;
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    checkOutput("restart_we", 32'(memWe), 1);
    checkOutput("restart_addr", 32'(memAddr), 0);
    checkOutput("restart_wdata", 32'(memWdata), 0);
    checkOutput("restart_ready", 32'(inReady), 0);
    checkOutput("restart_written", pixWritten, 0);
    checkOutput("restart_clipped", pixClipped, 0);
    checkOutput("restart_done", 32'(frameDone), 0);
    clr = 0;
    while (!inReady && clr < 400) begin
      nextCycle();
      clr++;
    end
    checkOutput("restart_clear_len", 32'(clr), DEPTH);
    checkOutput("restart_stage_empty", 32'(memWe), 0);
    checkOutput("restart_draw_written", pixWritten, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pixel_stream_sink.md
Name: pixel_stream_sink

Overview:
- Consumer end of the coordinate stream emitted by the shape generators (circle, rectangle, line). Each generator emits one signed (x, y) pair per cycle on _out0/_out1 and raises _done when finished.
- This block accepts those pairs over a valid/ready handshake and clips them to the framebuffer bounds. It converts each in-bounds pair to a linear address and writes the drawing colour into a single-port framebuffer write interface that can stall.
- Optionally clears the framebuffer first. Reports completion and pixel statistics back to the test/top level.

Parameters:
- WIDTH, 16, framebuffer width in pixels.
- HEIGHT, 12, framebuffer height in pixels.
- COLOR_W, 8, pixel colour width.
- ADDR_W, $clog2(WIDTH*HEIGHT), framebuffer address width.
- CLEAR_EN, 1, when 1 the framebuffer is cleared to BG_COLOR after _start.
- BG_COLOR, 0, background colour used during clear.

Ports:
- _clock  in  1  sole clock; all logic on posedge.
- _reset  in  1  synchronous, active-high reset.
- _start  in  1  begin a frame: sample draw_color, clear counters, enter CLEAR (or DRAW).
- draw_color  in  COLOR_W  colour for drawn pixels; sampled only on _start.
- in_valid  in  1  coordinate beat valid (generator output strobe).
- in_ready  out  1  sink can accept a beat this cycle.
- in_x  in  32 signed  pixel x (generator _out0).
- in_y  in  32 signed  pixel y (generator _out1).
- in_last  in  1  producer finished (generator _done); level or pulse.
- mem_we  out  1  framebuffer write request.
- mem_addr  out  ADDR_W  write address = y*WIDTH + x.
- mem_wdata  out  COLOR_W  write data.
- mem_ready  in  1  framebuffer accepts the write when mem_we && mem_ready.
- pixels_written  out  32  completed draw writes this frame (clear writes excluded).
- pixels_clipped  out  32  out-of-bounds beats dropped this frame.
- _done  out  1  frame complete; held until next _start or _reset.

Behaviour:
- Reset values: state IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, counters=0, _done=0, last_seen=0, stage empty.
- _reset has priority over _start. _start is honoured in any state; mid-operation it aborts any pending stage write (mem_we drops next cycle), zeroes counters and last_seen, clears _done, then enters CLEAR (CLEAR_EN=1) or DRAW.
- IDLE: in_ready=0, mem_we=0; waits for _start.
- CLEAR:
  - mem_we=1, mem_wdata=BG_COLOR; mem_addr starts at 0.
  - mem_addr advances by 1 on each mem_ready cycle and holds otherwise.
  - After the write at WIDTH*HEIGHT-1 is accepted, go to DRAW next cycle.
  - in_ready=0 throughout; in_last seen here still sets last_seen.
- DRAW, one-entry stage register S holding {valid, addr}:
  - in_ready = !S.valid || (mem_we && mem_ready).
  - mem_we = S.valid, mem_addr = S.addr, mem_wdata = latched draw_color.
  - On a handshake (in_valid && in_ready), the clip check is 0<=x<WIDTH and 0<=y<HEIGHT, using full signed 32-bit compares.
  - In-bounds: S loads {1, y*WIDTH+x}, truncated to ADDR_W. A beat can load in the same cycle S's write completes, giving throughput of 1 pixel/cycle with mem_ready=1.
  - Out-of-bounds: pixels_clipped+1; S is unchanged.
  - A write completing with no new in-bounds load clears S.valid.
  - Write latency: beat accepted at cycle N gives mem_we at N+1.
  - Duplicate coordinates (octant seams) are not filtered; each one is written and counted.
  - pixels_written+1 per completed draw write. Counters wrap at 2^32.
  - in_last sets sticky last_seen. When last_seen && !S.valid && no handshake this cycle, go to DONE.
  - in_last coincident with a valid beat: the beat is accepted and drained first.
- DONE: _done=1, in_ready=0, mem_we=0; counters hold.
- In DRAW, in_valid with in_ready=0 must be held by the producer; the sink does not drop beats.

Decomposition:
- Package pixel_sink_pkg holds:
  - state enum {IDLE, CLEAR, DRAW, DONE};
  - a constant function fb_depth(WIDTH, HEIGHT);
  - a shared coord_t (signed 32).
- One sub-module fb_addr_calc: combinational clip check plus address multiply-add. It is parameterised by WIDTH, HEIGHT and ADDR_W and outputs {in_bounds, addr}.

Test Plan:
- Reset for 2 cycles, then idle for 5 cycles -> all outputs 0, in_ready=0, _done=0.
- _start, draw_color=5, CLEAR_EN=1, mem_ready=1 -> 192 writes at addr 0..191 with wdata=0; in_ready rises on cycle 193; pixels_written=0.
- In DRAW, beats (3,2), (15,11), (0,0) back-to-back with mem_ready=1 -> writes at addr 35, 191, 0 with wdata=5 on consecutive cycles; pixels_written=3.
- Beats (-1,0), (16,0), (0,12), (0,-2147483648) -> no mem_we, pixels_clipped=4, in_ready stays 1.
- Beat (1,1) with mem_ready=0 for 4 cycles, (2,1) held valid -> mem_addr=17 stable, in_ready=0. In the cycle mem_ready=1, (2,1) is accepted; next cycle mem_addr=18.
- Integration with the circle generator, centre (8,6), radius 3, in_last tied to its _done:
  - _done asserts 1 cycle after the final write drains;
  - pixels_written + pixels_clipped = the generator beat count;
  - a second _start mid-DRAW restarts the clear with counters at 0.
